mdu_seq: RTL and testbench
==========================

MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; legal values are 4 to 64.
REQ-002 Port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit, synchronous active-high reset.
REQ-004 Port start, input, 1 bit, request strobe from the execute stage.
REQ-005 Port alucontrol, input, 8 bits, operation code using the shared EXE_*_OP encoding.
REQ-006 Ports a and b, input, WIDTH bits each; a is the multiplicand or dividend, b is the multiplier or divisor.
REQ-007 Port flush, input, 1 bit, pipeline flush that cancels any operation in flight.
REQ-008 Ports hi and lo, output, WIDTH bits each, result registers.
REQ-009 Port done, output, 1 bit, one-cycle completion pulse.
REQ-010 Port stall, output, 1 bit, pipeline stall request.

Function
REQ-011 States SHALL be IDLE, MUL, DIV and FIN.
REQ-012 A request SHALL be accepted only in IDLE when start=1, flush=0 and alucontrol is one of EXE_MULT_OP, EXE_MULTU_OP, EXE_DIV_OP or EXE_DIVU_OP; every other start is ignored with no state change.
REQ-013 On acceptance, a, b and the signedness SHALL be latched; the next state is MUL for MULT/MULTU and DIV for DIV/DIVU.
REQ-014 MUL SHALL last exactly 1 cycle.
  - It writes {hi,lo} with the 2*WIDTH-bit product: signed for MULT, unsigned for MULTU.
  - The next state is FIN.
REQ-015 DIV SHALL run a restoring radix-2 divide on magnitudes for exactly WIDTH cycles, then go to FIN.
  - Sign fix-up: lo (quotient) is negated when the operand signs differ; hi (remainder) takes the sign of the dividend.
  - DIVU uses no fix-up.
REQ-016 For DIV with a = most-negative and b = -1, the result SHALL be lo = most-negative and hi = 0, with no trap.
REQ-017 When the divisor is zero, DIV SHALL take 1 cycle only and write lo = all-ones and hi = latched a.
REQ-018 FIN SHALL assert done for exactly 1 cycle and then return to IDLE.
REQ-019 Latency from the accept edge to done high SHALL be:
  - MUL: 2 cycles.
  - DIV: WIDTH+1 cycles.
  - Divide-by-zero: 2 cycles.
REQ-020 stall SHALL be combinational: 1 when an accepting start is present in IDLE, or when the state is MUL or DIV; 0 in FIN and in otherwise idle cycles.
REQ-021 hi and lo SHALL hold their values from FIN until the next accepted operation writes them.
  - They do not change during DIV iterations; the working registers are internal.
REQ-022 start during MUL, DIV or FIN SHALL be ignored.
REQ-023 flush in MUL or DIV SHALL force IDLE on the next edge.
  - hi/lo stay unchanged, done is not asserted, and stall drops combinationally in the flush cycle.
REQ-024 flush in FIN SHALL NOT suppress done; hi/lo are already committed.
REQ-025 flush has priority over start in IDLE, so start+flush in the same cycle SHALL not be accepted.

Reset
REQ-026 When rst=1 at an edge, the next state SHALL be:
  - state = IDLE;
  - hi = 0, lo = 0;
  - done = 0;
  - internal counters and working registers = 0.
REQ-027 stall SHALL be 0 while rst is asserted.
REQ-028 rst SHALL take precedence over flush and start, including mid-DIV, and the aborted operation SHALL leave no residue.

Structure
REQ-029 The EXE_*_OP codes SHALL come only from the shared defines header, with no local redefinition.
REQ-030 The state encoding and the iteration counter width ($clog2(WIDTH)+1) SHALL be localparams in mdu_seq.
REQ-031 The iterative divider datapath SHALL be a sub-module named div_iter.
  - Inputs: clk, rst, load, dividend, divisor.
  - Outputs: quotient, remainder, ready.
  - The multiply, sign fix-up and FSM stay in mdu_seq.

Verification
REQ-032 MULT: a = 0xFFFFFFFE (-2), b = 3 -> done 2 cycles after accept; hi = 0xFFFFFFFF, lo = 0xFFFFFFFA; stall high 2 cycles.
REQ-033 DIV: a = -7, b = 2 -> done 33 cycles after accept; lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU with a = 7, b = 2 -> lo = 3, hi = 1.
REQ-034 DIV: a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0. DIVU with b = 0, a = 5 -> done after 2 cycles, lo = 0xFFFFFFFF, hi = 5.
REQ-035 Flush at DIV cycle 10 -> IDLE next cycle, no done, hi/lo keep the prior values. A second start during DIV is ignored.
REQ-036 rst pulsed mid-DIV -> hi = lo = 0, stall = 0. A subsequent MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi = 0xFFFFFFFE, lo = 1.
REQ-037 WIDTH=8 build: DIV -128 / -1 -> lo = 0x80, hi = 0, done 9 cycles after accept. start with alucontrol = EXE_ADD_OP -> no stall, no done.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// Shared execute-stage operation codes and small decode helpers for the
// sequential multiply/divide unit.
package mdu_seq_pkg;

   localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
   localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
   localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
   localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;

   function automatic logic is_mul_op(input logic [7:0] op);
      return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
   endfunction

   function automatic logic is_mdu_op(input logic [7:0] op);
      return is_mul_op(op) || (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
   endfunction

   function automatic logic is_signed_op(input logic [7:0] op);
      return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
   endfunction

endpackage

// File: rtl/div_iter.sv
// Restoring radix-2 divider on unsigned magnitudes. The load edge already
// performs the first iteration, so ready rises after WIDTH-1 further edges.
module div_iter
   import mdu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             ready
);

   logic [WIDTH-1:0] rem_reg, quo_reg, dvs_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] src_rem, src_quo, src_dvs;
   logic [WIDTH-1:0] rem_next, quo_next;
   logic [WIDTH:0]   shifted, diff;

   always_comb begin
      src_rem  = load ? '0 : rem_reg;
      src_quo  = load ? dividend : quo_reg;
      src_dvs  = load ? divisor : dvs_reg;
      shifted  = {src_rem, src_quo[WIDTH-1]};
      diff     = shifted - {1'b0, src_dvs};
      // Partial remainder stays below the divisor, so bit WIDTH of diff is the borrow.
      if (!diff[WIDTH]) begin
         rem_next = diff[WIDTH-1:0];
         quo_next = {src_quo[WIDTH-2:0], 1'b1};
      end else begin
         rem_next = shifted[WIDTH-1:0];
         quo_next = {src_quo[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_reg <= '0;
         quo_reg <= '0;
         dvs_reg <= '0;
         cnt_reg <= '0;
      end else if (load) begin
         rem_reg <= rem_next;
         quo_reg <= quo_next;
         dvs_reg <= divisor;
         cnt_reg <= CNT_W'(1);
      end else if (cnt_reg != '0 && cnt_reg != CNT_W'(WIDTH)) begin
         rem_reg <= rem_next;
         quo_reg <= quo_next;
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

   assign quotient  = quo_reg;
   assign remainder = rem_reg;
   assign ready     = (cnt_reg == CNT_W'(WIDTH));

endmodule

// File: rtl/mdu_seq.sv
// Sequential multiply/divide unit: single-cycle multiply, WIDTH-cycle
// restoring divide, with pipeline stall, flush and done handshake.
module mdu_seq
   import mdu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       alucontrol,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             done,
   output logic             stall
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIN  = 2'd3;
   localparam int         CNT_W  = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = S_IDLE,
      MUL  = S_MUL,
      DIV  = S_DIV,
      FIN  = S_FIN
   } state_t;

   state_t state_reg, state_next;

   logic [WIDTH-1:0]   a_reg, b_reg, hi_reg, lo_reg;
   logic               sgn_reg, dz_reg;
   logic               accept, div_load, sgn_in, div_ready;
   logic [WIDTH-1:0]   mag_a, mag_b, div_q, div_r, fix_q, fix_r;
   logic [2*WIDTH-1:0] ext_a, ext_b, prod;

   assign accept = start && !flush && is_mdu_op(alucontrol);
   assign sgn_in = is_signed_op(alucontrol);
   assign mag_a  = (sgn_in && a[WIDTH-1]) ? -a : a;
   assign mag_b  = (sgn_in && b[WIDTH-1]) ? -b : b;

   div_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_div_iter (
      .clk       (clk),
      .rst       (rst),
      .load      (div_load),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (div_q),
      .remainder (div_r),
      .ready     (div_ready)
   );

   assign ext_a = {{WIDTH{sgn_reg & a_reg[WIDTH-1]}}, a_reg};
   assign ext_b = {{WIDTH{sgn_reg & b_reg[WIDTH-1]}}, b_reg};
   assign prod  = ext_a * ext_b;
   // Quotient sign follows the operand signs; remainder follows the dividend.
   assign fix_q = (sgn_reg && (a_reg[WIDTH-1] ^ b_reg[WIDTH-1])) ? -div_q : div_q;
   assign fix_r = (sgn_reg && a_reg[WIDTH-1]) ? -div_r : div_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      stall      = 1'b0;
      done       = 1'b0;
      div_load   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               stall      = 1'b1;
               div_load   = 1'b1;
               state_next = is_mul_op(alucontrol) ? MUL : DIV;
            end
         end
         MUL: begin
            if (flush) begin
               state_next = IDLE;
            end else begin
               stall      = 1'b1;
               state_next = FIN;
            end
         end
         DIV: begin
            if (flush) begin
               state_next = IDLE;
            end else begin
               stall = 1'b1;
               if (dz_reg || div_ready) begin
                  state_next = FIN;
               end
            end
         end
         FIN: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (rst) begin
         stall = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg   <= '0;
         b_reg   <= '0;
         sgn_reg <= 1'b0;
         dz_reg  <= 1'b0;
         hi_reg  <= '0;
         lo_reg  <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  a_reg   <= a;
                  b_reg   <= b;
                  sgn_reg <= sgn_in;
                  dz_reg  <= (b == '0);
               end
            end
            MUL: begin
               if (!flush) begin
                  {hi_reg, lo_reg} <= prod;
               end
            end
            DIV: begin
               if (!flush) begin
                  if (dz_reg) begin
                     lo_reg <= '1;
                     hi_reg <= a_reg;
                  end else if (div_ready) begin
                     lo_reg <= fix_q;
                     hi_reg <= fix_r;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign hi = hi_reg;
   assign lo = lo_reg;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: a transaction-level model checked every
// cycle on a 32-bit and an 8-bit instance, plus hand-computed literal results.
module tb_mdu_seq;
   import mdu_seq_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        start0, flush0, done0, stall0;
   logic [7:0]  op0;
   logic [31:0] a0, b0, hi0, lo0;
   logic        start1, flush1, done1, stall1;
   logic [7:0]  op1;
   logic [7:0]  a1, b1, hi1, lo1;

   mdu_seq #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .start(start0), .alucontrol(op0), .a(a0), .b(b0),
      .flush(flush0), .hi(hi0), .lo(lo0), .done(done0), .stall(stall0)
   );

   mdu_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start1), .alucontrol(op1), .a(a1), .b(b1),
      .flush(flush1), .hi(hi1), .lo(lo1), .done(done1), .stall(stall1)
   );

   int errors = 0;
   int checks = 0;
   bit armed  = 1'b0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Arithmetic reference: plain signed/unsigned math on longint, masked to w bits.
   task automatic model_op(input logic [7:0] op, input longint ua, input longint ub,
                           input int w, output longint mh, output longint ml,
                           output int busy);
      longint mask, sa, sb, p, q, r;
      mask = (longint'(1) <<< w) - 1;
      sa   = ua[w-1] ? ua - (longint'(1) <<< w) : ua;
      sb   = ub[w-1] ? ub - (longint'(1) <<< w) : ub;
      mh = 0; ml = 0; busy = 1;
      if (op == EXE_MULT_OP || op == EXE_MULTU_OP) begin
         p  = (op == EXE_MULT_OP) ? sa * sb : ua * ub;
         mh = (p >>> w) & mask;
         ml = p & mask;
      end else if (ub == 0) begin
         mh = ua;
         ml = mask;
      end else begin
         q = (op == EXE_DIV_OP) ? sa / sb : ua / ub;
         r = (op == EXE_DIV_OP) ? sa % sb : ua % ub;
         mh = r & mask;
         ml = q & mask;
         busy = w;
      end
   endtask

   // Per-instance model state: busy cycles left, done expected, committed hi/lo.
   int     rem_busy [2];
   bit     fin_now  [2];
   longint hnow [2], lnow [2], ph [2], pl [2];

   task automatic step(input int i);
      bit st, fl, dn, sl, legal, idle, stall_exp;
      logic [7:0] op;
      longint ua, ub, h, l;
      int w, busy;
      st = (i == 0) ? start0 : start1;
      fl = (i == 0) ? flush0 : flush1;
      op = (i == 0) ? op0 : op1;
      ua = (i == 0) ? longint'(a0) : longint'(a1);
      ub = (i == 0) ? longint'(b0) : longint'(b1);
      dn = (i == 0) ? done0 : done1;
      sl = (i == 0) ? stall0 : stall1;
      h  = (i == 0) ? longint'(hi0) : longint'(hi1);
      l  = (i == 0) ? longint'(lo0) : longint'(lo1);
      w  = (i == 0) ? 32 : 8;
      legal = (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
              (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
      idle  = (rem_busy[i] == 0) && !fin_now[i];
      stall_exp = !rst && !fl && ((rem_busy[i] > 0) || (idle && st && legal));
      chk($sformatf("model_done%0d", i), longint'(dn), longint'(fin_now[i]));
      chk($sformatf("model_stall%0d", i), longint'(sl), longint'(stall_exp));
      chk($sformatf("model_hi%0d", i), h, hnow[i]);
      chk($sformatf("model_lo%0d", i), l, lnow[i]);
      if (rst) begin
         rem_busy[i] = 0; fin_now[i] = 0; hnow[i] = 0; lnow[i] = 0;
      end else if (fin_now[i]) begin
         fin_now[i] = 0;
      end else if (rem_busy[i] > 0) begin
         if (fl) begin
            rem_busy[i] = 0;
         end else begin
            rem_busy[i]--;
            if (rem_busy[i] == 0) begin
               fin_now[i] = 1; hnow[i] = ph[i]; lnow[i] = pl[i];
            end
         end
      end else if (st && !fl && legal) begin
         model_op(op, ua, ub, w, ph[i], pl[i], busy);
         rem_busy[i] = busy;
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (armed) begin
            for (int i = 0; i < 2; i++) step(i);
         end
      end
   end

   task automatic drive(input int i, input bit st, input logic [7:0] op,
                        input longint a, input longint b);
      if (i == 0) begin
         start0 = st; op0 = op; a0 = a[31:0]; b0 = b[31:0];
      end else begin
         start1 = st; op1 = op; a1 = a[7:0]; b1 = b[7:0];
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation, wait (bounded) for done, check literal expectations.
   task automatic run_op(input int i, input string tag, input logic [7:0] op,
                         input longint a, input longint b, input int exp_lat,
                         input int exp_stall, input longint exp_hi, input longint exp_lo);
      int lat, nstall;
      bit got, dn;
      next_cycle();
      drive(i, 1'b1, op, a, b);
      @(negedge clk);
      nstall = (i == 0) ? int'(stall0) : int'(stall1);
      next_cycle();
      drive(i, 1'b0, op, a, b);
      lat = 0;
      got = 1'b0;
      repeat (100) begin
         @(negedge clk);
         lat++;
         dn = (i == 0) ? done0 : done1;
         if (dn) begin
            got = 1'b1;
            break;
         end
         nstall += (i == 0) ? int'(stall0) : int'(stall1);
      end
      chk({tag, "_done_seen"}, longint'(got), 1);
      chk({tag, "_latency"}, lat, exp_lat);
      if (exp_stall >= 0) chk({tag, "_stall_cycles"}, nstall, exp_stall);
      chk({tag, "_hi"}, (i == 0) ? longint'(hi0) : longint'(hi1), exp_hi);
      chk({tag, "_lo"}, (i == 0) ? longint'(lo0) : longint'(lo1), exp_lo);
      $display("op %s: hi=%0h lo=%0h latency=%0d", tag,
               (i == 0) ? hi0 : 32'(hi1), (i == 0) ? lo0 : 32'(lo1), lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ndone;
      rst = 1'b1;
      flush0 = 1'b0; flush1 = 1'b0;
      drive(0, 1'b0, EXE_NOP_OP, 0, 0);
      drive(1, 1'b0, EXE_NOP_OP, 0, 0);
      next_cycle();
      armed = 1'b1;
      @(negedge clk);
      chk("reset_hi", longint'(hi0), 0);
      chk("reset_lo", longint'(lo0), 0);
      chk("reset_done", longint'(done0), 0);
      chk("reset_stall", longint'(stall0), 0);
      next_cycle();
      rst = 1'b0;

      run_op(0, "mult_m2x3", EXE_MULT_OP, 64'hFFFF_FFFE, 3, 2, 2, 64'hFFFF_FFFF, 64'hFFFF_FFFA);
      run_op(0, "div_m7d2", EXE_DIV_OP, 64'hFFFF_FFF9, 2, 33, 33, 64'hFFFF_FFFF, 64'hFFFF_FFFD);
      run_op(0, "divu_7d2", EXE_DIVU_OP, 7, 2, 33, 33, 1, 3);
      run_op(0, "div_min_m1", EXE_DIV_OP, 64'h8000_0000, 64'hFFFF_FFFF, 33, -1, 0, 64'h8000_0000);
      run_op(0, "divu_by0", EXE_DIVU_OP, 5, 0, 2, 2, 5, 64'hFFFF_FFFF);
      run_op(0, "divu_7d2_again", EXE_DIVU_OP, 7, 2, 33, -1, 1, 3);

      // Flush at DIV cycle 10 with a stray start in cycle 4.
      next_cycle();
      drive(0, 1'b1, EXE_DIV_OP, 100, 7);
      next_cycle();
      drive(0, 1'b0, EXE_DIV_OP, 100, 7);
      repeat (3) next_cycle();
      drive(0, 1'b1, EXE_MULT_OP, 3, 4);
      next_cycle();
      drive(0, 1'b0, EXE_MULT_OP, 3, 4);
      repeat (5) next_cycle();
      flush0 = 1'b1;
      @(negedge clk);
      chk("flush_stall", longint'(stall0), 0);
      next_cycle();
      flush0 = 1'b0;
      @(negedge clk);
      chk("flush_after_stall", longint'(stall0), 0);
      chk("flush_after_hi", longint'(hi0), 1);
      chk("flush_after_lo", longint'(lo0), 3);
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         ndone += int'(done0);
      end
      chk("flush_no_done", ndone, 0);
      $display("op flush_mid_div: hi=%0h lo=%0h", hi0, lo0);

      // start together with flush in IDLE is not accepted.
      next_cycle();
      flush0 = 1'b1;
      drive(0, 1'b1, EXE_MULT_OP, 5, 5);
      @(negedge clk);
      chk("start_flush_stall", longint'(stall0), 0);
      next_cycle();
      flush0 = 1'b0;
      drive(0, 1'b0, EXE_MULT_OP, 5, 5);
      ndone = 0;
      repeat (4) begin
         @(negedge clk);
         ndone += int'(done0);
      end
      chk("start_flush_no_done", ndone, 0);
      $display("op start_with_flush: done_count=%0d", ndone);

      // Reset in the middle of a divide.
      next_cycle();
      drive(0, 1'b1, EXE_DIV_OP, 1000, 3);
      next_cycle();
      drive(0, 1'b0, EXE_DIV_OP, 1000, 3);
      repeat (4) next_cycle();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_stall", longint'(stall0), 0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_hi", longint'(hi0), 0);
      chk("rst_mid_lo", longint'(lo0), 0);
      chk("rst_mid_done", longint'(done0), 0);
      chk("rst_mid_stall_after", longint'(stall0), 0);
      $display("op rst_mid_div: hi=%0h lo=%0h", hi0, lo0);
      run_op(0, "multu_max", EXE_MULTU_OP, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 2, 2, 64'hFFFF_FFFE, 1);

      // 8-bit instance.
      run_op(1, "w8_div_min_m1", EXE_DIV_OP, 8'h80, 8'hFF, 9, 9, 0, 8'h80);
      run_op(1, "w8_div_m7d2", EXE_DIV_OP, 8'hF9, 2, 9, -1, 8'hFF, 8'hFD);
      run_op(1, "w8_multu_max", EXE_MULTU_OP, 8'hFF, 8'hFF, 2, 2, 8'hFE, 8'h01);
      next_cycle();
      drive(1, 1'b1, EXE_ADD_OP, 3, 4);
      @(negedge clk);
      chk("w8_add_stall", longint'(stall1), 0);
      next_cycle();
      drive(1, 1'b0, EXE_ADD_OP, 3, 4);
      ndone = 0;
      repeat (4) begin
         @(negedge clk);
         ndone += int'(done1);
      end
      chk("w8_add_no_done", ndone, 0);
      $display("op w8_add_ignored: done_count=%0d", ndone);

      repeat (3) next_cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
